// File: rtl/eth_udp_tx_pkg.sv
// Shared constants, transmit state codes and the byte-wide CRC-32 step used by
// the Ethernet/IPv4/UDP transmit path.
package eth_udp_tx_pkg;

  localparam logic [7:0]  ETH_PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  ETH_SFD           = 8'hD5;
  localparam logic [15:0] ETHERTYPE_IPV4    = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP      = 8'h11;
  localparam int          ETH_MIN_PAYLOAD   = 46;
  localparam logic [31:0] CRC32_POLY_REFL   = 32'hEDB88320;

  localparam logic [10:0] UDP_MAX_PAYLOAD   = 11'd1472;
  // Payloads shorter than this need zero padding to reach a 60-byte frame.
  localparam logic [10:0] UDP_MIN_UNPADDED  = 11'(ETH_MIN_PAYLOAD - 28);

  typedef logic [3:0] eth_tx_states;
  localparam eth_tx_states TX_IDLE     = 4'd0;
  localparam eth_tx_states TX_PREAMBLE = 4'd1;
  localparam eth_tx_states TX_ETH_HDR  = 4'd2;
  localparam eth_tx_states TX_IP_HDR   = 4'd3;
  localparam eth_tx_states TX_UDP_HDR  = 4'd4;
  localparam eth_tx_states TX_PAYLOAD  = 4'd5;
  localparam eth_tx_states TX_PAD      = 4'd6;
  localparam eth_tx_states TX_FCS      = 4'd7;
  localparam eth_tx_states TX_IFG      = 4'd8;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'd0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_udp_tx_if.sv
// Byte streams around the frame builder: payload in from the upstream buffer,
// frame bytes out to the RMII serializer.
interface eth_udp_tx_if;
  logic [7:0] payload_data;
  logic       payload_valid;
  logic       payload_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_last;

  modport master (
    input  payload_data, payload_valid, tx_ready,
    output payload_ready, tx_data, tx_valid, tx_last
  );

  modport slave (
    output payload_data, payload_valid, tx_ready,
    input  payload_ready, tx_data, tx_valid, tx_last
  );
endinterface

// File: rtl/eth_udp_tx_crc32.sv
// Byte-wide Ethernet CRC-32 (reflected, init all-ones). crc is the raw register;
// the caller inverts it for the FCS or compares it against the residue on receive.
module eth_crc32
  import eth_udp_tx_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  // NOTE: state is written with <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || init) begin
      crc <= 32'hFFFF_FFFF;
    end else if (en) begin
      crc <= crc32_byte(crc, data);
    end
  end

endmodule

// File: rtl/eth_udp_tx.sv
// Builds Ethernet II / IPv4 / UDP frames around a streamed payload and hands
// them byte by byte to the RMII serializer, followed by the inter-frame gap.
module eth_udp_tx
  import eth_udp_tx_pkg::*;
#(
  parameter logic [47:0] FPGA_MAC   = 48'h00_1A_2B_3C_4D_5E,
  parameter logic [31:0] FPGA_IP    = 32'hC0_00_02_92,
  parameter logic [15:0] FPGA_PORT  = 16'd5005,
  parameter logic [7:0]  IP_TTL     = 8'd64,
  parameter int          IFG_CYCLES = 96
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [10:0] payload_len,
  input  logic [47:0] dest_mac,
  input  logic [31:0] dest_ip,
  input  logic [15:0] dest_port,
  output logic        busy,
  output logic        tx_underrun,
  eth_udp_tx_if.master bus
);

  localparam int IFG_W = $clog2(IFG_CYCLES + 1);

  eth_tx_states     state, next_state;
  logic [10:0]      cnt, sect_last, len, len_in;
  logic [IFG_W-1:0] ifg_cnt;
  logic [47:0]      dmac;
  logic [31:0]      dip;
  logic [15:0]      dport, ident;
  logic [15:0]      total_len_in, total_len, udp_len;
  logic [31:0]      cks_acc, cks_seed, crc;
  logic             accept, adv, crc_en;

  logic [0:13][7:0] eth_hdr;
  logic [0:19][7:0] ip_hdr;
  logic [0:7][7:0]  udp_hdr;
  logic [3:0][7:0]  fcs;

  assign accept = (state == TX_IDLE) && start;
  assign adv    = bus.tx_valid && bus.tx_ready;
  assign busy   = (state != TX_IDLE);

  always_comb begin
    if (payload_len == 11'd0)                 len_in = 11'd1;
    else if (payload_len > UDP_MAX_PAYLOAD)   len_in = UDP_MAX_PAYLOAD;
    else                                      len_in = payload_len;
  end

  assign total_len_in = 16'd28 + {5'd0, len_in};
  assign total_len    = 16'd28 + {5'd0, len};
  assign udp_len      = 16'd8  + {5'd0, len};

  // Sum of the nine non-zero header words; folded down while the preamble goes out.
  assign cks_seed = 32'h0000_4500 + {16'd0, total_len_in} + {16'd0, ident} + 32'h0000_4000
                  + {16'd0, IP_TTL, IP_PROTO_UDP}
                  + {16'd0, FPGA_IP[31:16]} + {16'd0, FPGA_IP[15:0]}
                  + {16'd0, dest_ip[31:16]} + {16'd0, dest_ip[15:0]};

  assign eth_hdr = {dmac, FPGA_MAC, ETHERTYPE_IPV4};
  assign ip_hdr  = {8'h45, 8'h00, total_len, ident, 16'h4000, IP_TTL, IP_PROTO_UDP,
                    ~cks_acc[15:0], FPGA_IP, dip};
  assign udp_hdr = {FPGA_PORT, dport, udp_len, 16'h0000};
  assign fcs     = ~crc;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    sect_last  = 11'd0;
    next_state = TX_IDLE;
    case (state)
      TX_PREAMBLE: begin sect_last = 11'd7;  next_state = TX_ETH_HDR; end
      TX_ETH_HDR:  begin sect_last = 11'd13; next_state = TX_IP_HDR;  end
      TX_IP_HDR:   begin sect_last = 11'd19; next_state = TX_UDP_HDR; end
      TX_UDP_HDR:  begin sect_last = 11'd7;  next_state = TX_PAYLOAD; end
      TX_PAYLOAD: begin
        sect_last  = len - 11'd1;
        next_state = (len < UDP_MIN_UNPADDED) ? TX_PAD : TX_FCS;
      end
      TX_PAD:      begin sect_last = UDP_MIN_UNPADDED - len - 11'd1; next_state = TX_FCS; end
      TX_FCS:      begin sect_last = 11'd3;  next_state = TX_IFG;     end
      default: ;
    endcase
  end

  always_comb begin
    bus.tx_data = 8'h00;
    case (state)
      TX_PREAMBLE: bus.tx_data = (cnt == 11'd7) ? ETH_SFD : ETH_PREAMBLE_BYTE;
      TX_ETH_HDR:  bus.tx_data = eth_hdr[cnt[3:0]];
      TX_IP_HDR:   bus.tx_data = ip_hdr[cnt[4:0]];
      TX_UDP_HDR:  bus.tx_data = udp_hdr[cnt[2:0]];
      TX_PAYLOAD:  bus.tx_data = bus.payload_valid ? bus.payload_data : 8'h00;
      TX_FCS:      bus.tx_data = fcs[cnt[1:0]];
      default: ;
    endcase
  end

  assign bus.tx_valid      = (state != TX_IDLE) && (state != TX_IFG);
  assign bus.tx_last       = (state == TX_FCS) && (cnt == 11'd3);
  assign bus.payload_ready = (state == TX_PAYLOAD) && bus.payload_valid && bus.tx_ready;
  assign crc_en = adv && (state inside {TX_ETH_HDR, TX_IP_HDR, TX_UDP_HDR, TX_PAYLOAD, TX_PAD});

  eth_crc32 u_crc (
    .clk  (clk),
    .reset(reset),
    .init (accept),
    .en   (crc_en),
    .data (bus.tx_data),
    .crc  (crc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= TX_IDLE;
      cnt         <= '0;
      ifg_cnt     <= '0;
      ident       <= '0;
      tx_underrun <= 1'b0;
    end else begin
      case (state)
        TX_IDLE: begin
          if (start) begin
            state       <= TX_PREAMBLE;
            cnt         <= '0;
            tx_underrun <= 1'b0;
          end
        end
        TX_IFG: begin
          if (ifg_cnt == IFG_W'(IFG_CYCLES - 1)) begin
            state   <= TX_IDLE;
            ifg_cnt <= '0;
          end else begin
            ifg_cnt <= ifg_cnt + IFG_W'(1);
          end
        end
        default: begin
          if (adv) begin
            if (cnt == sect_last) begin
              cnt   <= '0;
              state <= next_state;
            end else begin
              cnt <= cnt + 11'd1;
            end
          end
        end
      endcase
      if (adv && (state == TX_FCS) && (cnt == 11'd3)) ident <= ident + 16'd1;
      // The wire cannot stall, so a missing payload byte goes out as zero.
      if (adv && (state == TX_PAYLOAD) && !bus.payload_valid) tx_underrun <= 1'b1;
    end
  end

  // NOTE: frame fields and the checksum accumulator are pure datapath, loaded on
  // every accepted start, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      dmac    <= dest_mac;
      dip     <= dest_ip;
      dport   <= dest_port;
      len     <= len_in;
      cks_acc <= cks_seed;
    end else if (state == TX_PREAMBLE) begin
      cks_acc <= {16'd0, cks_acc[15:0]} + {16'd0, cks_acc[31:16]};
    end
  end

endmodule
